// File: rtl/fir_tap_sequencer.sv
// -----------------------------------------------------------------------------
// fir_tap_sequencer
//
// Time-multiplexed stereo FIR controller. Each accepted sample is written into
// its channel's circular delay line, then one shared multiply-accumulate is
// stepped over NUM_TAPS taps using coefficients from an external synchronous
// ROM. The rounded, saturated result is held on the output until taken.
//
// Ports
//   clk            clock
//   rst            synchronous reset, active-high
//   s_axis_tdata   input sample (signed)
//   s_axis_tvalid  input valid
//   s_axis_tready  input ready, high only while idle
//   s_axis_tlast   channel select of the input sample (0 = L, 1 = R)
//   m_axis_tdata   filtered sample (signed)
//   m_axis_tvalid  output valid
//   m_axis_tready  downstream ready
//   m_axis_tlast   channel of the held result
//   coef_addr      coefficient ROM address (tap index)
//   coef_data      coefficient ROM data, one cycle after coef_addr
//   busy           high whenever not idle
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | zero one entry of both delay lines per cycle (NUM_TAPS cycles)
// ST_IDLE  | ready for a sample; on handshake store it and start the MAC
// ST_MAC   | one tap per cycle: address ROM, fetch delay-line sample
// ST_DRAIN | accumulate the last product, register rounded result
// ST_OUT   | result valid and held until downstream takes it
// -----------------------------------------------------------------------------
module fir_tap_sequencer #(
   parameter int DATA_WIDTH = 24,
   parameter int COEF_WIDTH = 16,
   parameter int COEF_FRAC  = 15,
   parameter int NUM_TAPS   = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ACC_WIDTH  = 48
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [ADDR_WIDTH-1:0] coef_addr,
   input  logic [COEF_WIDTH-1:0] coef_data,
   output logic                  busy
);

   typedef enum logic [2:0] {
      ST_CLEAR = 3'd0,
      ST_IDLE  = 3'd1,
      ST_MAC   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_OUT   = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ONE_A  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] LAST_K = {ADDR_WIDTH{1'b1}};

   // Round-half-up constant and output saturation limits, all at accumulator width.
   localparam logic signed [ACC_WIDTH-1:0] RND =
      {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (COEF_FRAC-1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0]       k_q, k_d;
   logic [ADDR_WIDTH-1:0]       clr_cnt_q, clr_cnt_d;
   logic                        ch_q, ch_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [DATA_WIDTH-1:0]       samp_q, samp_d;
   logic                        mac_v_q, mac_v_d;
   logic [ADDR_WIDTH-1:0]       wr_ptr_q [2];
   logic [ADDR_WIDTH-1:0]       wr_ptr_d [2];
   logic [DATA_WIDTH-1:0]       tdata_q, tdata_d;
   logic                        tlast_q, tlast_d;

   logic [DATA_WIDTH-1:0]       line_q [2][NUM_TAPS];

   logic                        accept;
   logic [ADDR_WIDTH-1:0]       rd_idx;
   logic [DATA_WIDTH-1:0]       rd_sample;
   logic signed [ACC_WIDTH-1:0] samp_ext;
   logic signed [ACC_WIDTH-1:0] coef_ext;
   logic signed [ACC_WIDTH-1:0] prod_ext;
   logic signed [ACC_WIDTH-1:0] acc_sum;
   logic signed [ACC_WIDTH-1:0] acc_rnd;
   logic signed [ACC_WIDTH-1:0] acc_shr;
   logic [DATA_WIDTH-1:0]       sat_result;

   assign accept = (state_q == ST_IDLE) && s_axis_tvalid;

   // Tap k reads the sample written k samples ago; modular wrap is free at ADDR_WIDTH.
   assign rd_idx    = wr_ptr_q[ch_q] - k_q;
   assign rd_sample = line_q[ch_q][rd_idx];

   // samp_q and coef_data both refer to the tap addressed in the previous cycle.
   assign samp_ext = {{(ACC_WIDTH-DATA_WIDTH){samp_q[DATA_WIDTH-1]}}, samp_q};
   assign coef_ext = {{(ACC_WIDTH-COEF_WIDTH){coef_data[COEF_WIDTH-1]}}, coef_data};
   assign prod_ext = samp_ext * coef_ext;
   assign acc_sum  = acc_q + prod_ext;
   assign acc_rnd  = acc_sum + RND;
   assign acc_shr  = acc_rnd >>> COEF_FRAC;

   always_comb begin
      if (acc_shr > SAT_MAX) begin
         sat_result = SAT_MAX[DATA_WIDTH-1:0];
      end else if (acc_shr < SAT_MIN) begin
         sat_result = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         sat_result = acc_shr[DATA_WIDTH-1:0];
      end
   end

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_CLEAR;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLEAR: if (clr_cnt_q == '0)     state_d = ST_IDLE;
         ST_IDLE:  if (s_axis_tvalid)       state_d = ST_MAC;
         ST_MAC:   if (k_q == LAST_K)       state_d = ST_DRAIN;
         ST_DRAIN:                          state_d = ST_OUT;
         ST_OUT:   if (m_axis_tready)       state_d = ST_IDLE;
         default:                           state_d = ST_CLEAR;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      busy          = 1'b1;
      case (state_q)
         ST_IDLE: begin
            s_axis_tready = 1'b1;
            busy          = 1'b0;
         end
         ST_OUT:  m_axis_tvalid = 1'b1;
         default: ;
      endcase
   end

   assign m_axis_tdata = tdata_q;
   assign m_axis_tlast = tlast_q;
   // k_q is left at its final value after MAC, so the address holds outside MAC.
   assign coef_addr    = k_q;

   // ---------------------------------------------------------------- datapath
   always_comb begin
      k_d       = k_q;
      clr_cnt_d = clr_cnt_q;
      ch_d      = ch_q;
      acc_d     = acc_q;
      samp_d    = samp_q;
      mac_v_d   = (state_q == ST_MAC);
      wr_ptr_d  = wr_ptr_q;
      tdata_d   = tdata_q;
      tlast_d   = tlast_q;
      case (state_q)
         ST_CLEAR: begin
            if (clr_cnt_q != '0) clr_cnt_d = clr_cnt_q - ONE_A;
         end
         ST_IDLE: begin
            if (accept) begin
               ch_d  = s_axis_tlast;
               acc_d = '0;
               k_d   = '0;
            end
         end
         ST_MAC: begin
            samp_d = rd_sample;
            if (k_q != LAST_K) k_d = k_q + ONE_A;
            // First MAC cycle has no fetched tap yet.
            if (mac_v_q) acc_d = acc_sum;
         end
         ST_DRAIN: begin
            acc_d   = acc_sum;
            tdata_d = sat_result;
            tlast_d = ch_q;
         end
         ST_OUT: begin
            if (m_axis_tready) wr_ptr_d[ch_q] = wr_ptr_q[ch_q] + ONE_A;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_q         <= '0;
         clr_cnt_q   <= LAST_K;
         ch_q        <= 1'b0;
         acc_q       <= '0;
         samp_q      <= '0;
         mac_v_q     <= 1'b0;
         wr_ptr_q[0] <= '0;
         wr_ptr_q[1] <= '0;
         tdata_q     <= '0;
         tlast_q     <= 1'b0;
      end else begin
         k_q         <= k_d;
         clr_cnt_q   <= clr_cnt_d;
         ch_q        <= ch_d;
         acc_q       <= acc_d;
         samp_q      <= samp_d;
         mac_v_q     <= mac_v_d;
         wr_ptr_q[0] <= wr_ptr_d[0];
         wr_ptr_q[1] <= wr_ptr_d[1];
         tdata_q     <= tdata_d;
         tlast_q     <= tlast_d;
      end
   end

   // Delay lines carry no reset; CLEAR walks every entry after each reset.
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) begin
         line_q[0][clr_cnt_q] <= '0;
         line_q[1][clr_cnt_q] <= '0;
      end else if (accept) begin
         line_q[s_axis_tlast][wr_ptr_q[s_axis_tlast]] <= s_axis_tdata;
      end
   end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
module tb_fir_tap_sequencer;

   localparam int N = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic [23:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        m_axis_tlast;
   logic [4:0]  coef_addr;
   logic [15:0] coef_data;
   logic        busy;

   logic [15:0] coef_mem [N];

   int total = 0;
   int bad   = 0;

   longint hist_l[$];
   longint hist_r[$];

   always #5 clk = ~clk;

   always @(posedge clk) coef_data <= coef_mem[coef_addr];

   fir_tap_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .coef_addr     (coef_addr),
      .coef_data     (coef_data),
      .busy          (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: FIR as a plain dot product over each channel's sample history
   // (newest first, zeros beyond the history), then round half up and clamp.
   function automatic longint model_push(input bit ch, input logic [23:0] d);
      longint h[$];
      longint acc;
      longint r;
      if (ch) begin
         hist_r.push_front(longint'($signed(d)));
         if (hist_r.size() > N) void'(hist_r.pop_back());
         h = hist_r;
      end else begin
         hist_l.push_front(longint'($signed(d)));
         if (hist_l.size() > N) void'(hist_l.pop_back());
         h = hist_l;
      end
      acc = 0;
      for (int k = 0; k < h.size(); k++) acc += h[k] * longint'($signed(coef_mem[k]));
      r = (acc + 64'sd16384) >>> 15;
      if (r > 64'sd8388607)  r = 64'sd8388607;
      if (r < -64'sd8388608) r = -64'sd8388608;
      return r;
   endfunction

   task automatic do_reset();
      int  cnt;
      bit  tv_ok;
      @(negedge clk);
      rst = 1'b1;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tready", 64'(s_axis_tready), 64'd0);
      check("rst_busy",   64'(busy),          64'd1);
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_tdata",  64'(m_axis_tdata),  64'd0);
      check("rst_tlast",  64'(m_axis_tlast),  64'd0);
      check("rst_addr",   64'(coef_addr),     64'd0);
      rst = 1'b0;
      hist_l.delete();
      hist_r.delete();
      cnt   = 0;
      tv_ok = 1'b1;
      while (cnt < 200) begin
         @(posedge clk);
         #1;
         cnt++;
         if (m_axis_tvalid !== 1'b0) tv_ok = 1'b0;
         if (s_axis_tready === 1'b1) break;
      end
      check("clear_len",    64'(cnt),   64'(N));
      check("busy_fall",    64'(busy),  64'd0);
      check("clear_tvalid", 64'(tv_ok), 64'd1);
   endtask

   // One full transaction: wait for ready, hand over a sample, wait for the
   // result, optionally hold off the consumer, then take the result.
   task automatic send(input bit ch, input logic [23:0] d, input int hold,
                       output logic [23:0] got);
      int          j;
      longint      e;
      logic [23:0] e24;
      bit          stable;
      logic [31:0] junk;
      @(negedge clk);
      j = 0;
      while (s_axis_tready !== 1'b1 && j < 300) begin
         @(negedge clk);
         j++;
      end
      check("in_ready_wait", 64'(j < 300), 64'd1);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = ch;
      e   = model_push(ch, d);
      e24 = e[23:0];
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      j = 1;
      while (m_axis_tvalid !== 1'b1 && j < 300) begin
         @(negedge clk);
         j++;
      end
      check("latency",   64'(j),            64'(N + 2));
      check("tdata",     64'(m_axis_tdata), 64'(e24));
      check("tlast",     64'(m_axis_tlast), 64'(ch));
      check("addr_hold", 64'(coef_addr),    64'(N - 1));
      got = m_axis_tdata;
      if (hold > 0) begin
         stable = 1'b1;
         for (int i = 0; i < hold; i++) begin
            // Offer a stray sample while the result is held; it must be ignored.
            junk = $urandom();
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = junk[23:0];
            s_axis_tlast  = junk[24];
            @(negedge clk);
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== e24 || m_axis_tlast !== ch ||
                s_axis_tready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
         end
         s_axis_tvalid = 1'b0;
         check("bp_stable", 64'(stable), 64'd1);
      end
      m_axis_tready = 1'b1;
      @(negedge clk);
      m_axis_tready = 1'b0;
      check("tvalid_drop", 64'(m_axis_tvalid), 64'd0);
      check("ready_back",  64'(s_axis_tready), 64'd1);
   endtask

   task automatic load_ramp_coefs();
      for (int k = 0; k < N; k++) coef_mem[k] = 16'(1024 * (k + 1));
   endtask

   task automatic run_impulse(input bit interleave, input int hold_at, input int hold_len);
      logic [23:0] got;
      for (int n = 0; n < 41; n++) begin
         send(1'b0, (n == 0) ? 24'h040000 : 24'h000000, (n == hold_at) ? hold_len : 0, got);
         if (n == 0) check("impulse_first", 64'(got), 64'h2000);
         if (interleave) begin
            send(1'b1, 24'h000000, 0, got);
            check("iso_r_zero", 64'(got), 64'd0);
         end
      end
   endtask

   initial begin
      logic [23:0] got;
      logic [31:0] rnd;
      int          j;

      for (int k = 0; k < N; k++) coef_mem[k] = '0;

      // T1 reset / clear sweep
      do_reset();

      // T2 impulse response
      load_ramp_coefs();
      run_impulse(1'b0, -1, 0);

      // T3 channel isolation
      do_reset();
      run_impulse(1'b1, -1, 0);

      // T4 saturation both ways
      for (int k = 0; k < N; k++) coef_mem[k] = 16'h7FFF;
      for (int n = 0; n < N; n++) send(1'b0, 24'h7FFFFF, 0, got);
      check("sat_pos", 64'(got), 64'h7FFFFF);
      for (int n = 0; n < N; n++) send(1'b0, 24'h800000, 0, got);
      check("sat_neg", 64'(got), 64'h800000);

      // T5 backpressure
      do_reset();
      load_ramp_coefs();
      run_impulse(1'b0, 0, 100);
      run_impulse(1'b0, 7, 40);

      // T6 reset in the middle of the third sample's MAC
      send(1'b0, 24'h123456, 0, got);
      send(1'b1, 24'h654321, 0, got);
      @(negedge clk);
      j = 0;
      while (s_axis_tready !== 1'b1 && j < 300) begin
         @(negedge clk);
         j++;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 24'h0ABCDE;
      s_axis_tlast  = 1'b0;
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      j = 0;
      while (coef_addr !== 5'd10 && j < 300) begin
         @(negedge clk);
         j++;
      end
      check("mid_reach_k10", 64'(j < 300), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("mid_tready", 64'(s_axis_tready), 64'd0);
      check("mid_busy",   64'(busy),          64'd1);
      do_reset();
      run_impulse(1'b0, -1, 0);

      // T7 random coefficients, samples, channels and backpressure
      do_reset();
      for (int k = 0; k < N; k++) begin
         rnd = $urandom();
         coef_mem[k] = rnd[15:0];
      end
      for (int n = 0; n < 80; n++) begin
         rnd = $urandom();
         case ($urandom_range(0, 3))
            0:       send(rnd[31], 24'h7FFFFF, $urandom_range(0, 3), got);
            1:       send(rnd[31], 24'h800000, $urandom_range(0, 3), got);
            default: send(rnd[31], rnd[23:0],  $urandom_range(0, 3), got);
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
